// File: rtl/maj_vote_seq_if.sv
// Vote-in / result-out stream bundle for maj_vote_seq.
// master drives votes and consumes results; slave is the voter.
interface maj_vote_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] out_mask;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_mask
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_mask
    );
endinterface

// File: rtl/maj_vote_seq.sv
// Sequential bitwise majority voter: accumulates NVOTES words per frame and
// holds one majority/disagreement result until the consumer takes it.
module maj_vote_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NVOTES = 9,
    parameter int unsigned THRESH = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    maj_vote_seq_if.slave bus
);
    localparam int unsigned CW = $clog2(NVOTES + 1);
    localparam int unsigned IW = (NVOTES > 1) ? $clog2(NVOTES) : 1;
    localparam logic [CW-1:0] THR  = CW'(THRESH);
    localparam logic [CW-1:0] ALL  = CW'(NVOTES);
    localparam logic [IW-1:0] LAST = IW'(NVOTES - 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt    [WIDTH];
    logic [CW-1:0]    cnt_nx [WIDTH];
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] data_q, mask_q, data_nx, mask_nx;
    logic             accept, last, drain;

    assign bus.in_ready  = (state == COLLECT) && !clear;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = data_q;
    assign bus.out_mask  = mask_q;

    always_comb begin
        accept   = bus.in_valid && bus.in_ready;
        last     = accept && (idx == LAST);
        drain    = (state == HOLD) && bus.out_ready;
        state_nx = state;
        if (clear)
            state_nx = COLLECT;
        else if (last)
            state_nx = HOLD;
        else if (drain)
            state_nx = COLLECT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= COLLECT;
        else
            state <= state_nx;
    end

    // Result is decided from the counts including the word being accepted.
    always_comb begin
        data_nx = '0;
        mask_nx = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            cnt_nx[b]  = cnt[b] + CW'(bus.in_data[b]);
            data_nx[b] = (cnt_nx[b] >= THR);
            mask_nx[b] = (cnt_nx[b] != '0) && (cnt_nx[b] != ALL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < WIDTH; b++) cnt[b] <= '0;
            idx    <= '0;
            data_q <= '0;
            mask_q <= '0;
        end else if (clear) begin
            for (int unsigned b = 0; b < WIDTH; b++) cnt[b] <= '0;
            idx    <= '0;
            data_q <= '0;
            mask_q <= '0;
        end else if (accept) begin
            for (int unsigned b = 0; b < WIDTH; b++) cnt[b] <= cnt_nx[b];
            idx <= idx + IW'(1);
            if (last) begin
                data_q <= data_nx;
                mask_q <= mask_nx;
            end
        end else if (drain) begin
            for (int unsigned b = 0; b < WIDTH; b++) cnt[b] <= '0;
            idx <= '0;
        end
    end
endmodule

// File: tb/tb_maj_vote_seq.sv
// Scoreboard bench for maj_vote_seq: a per-frame ones-count model feeds an
// expectation queue that an independent monitor drains on each output handshake.
module tb_maj_vote_seq;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NVOTES = 9;
    localparam int unsigned THRESH = 5;

    logic clk = 0;
    logic rst_n = 0;
    logic clear = 0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    logic [2*WIDTH-1:0] exp_q[$];
    int                 hs_cyc[$];

    maj_vote_seq_if #(.WIDTH(WIDTH)) vif ();

    maj_vote_seq #(.WIDTH(WIDTH), .NVOTES(NVOTES), .THRESH(THRESH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (vif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: count ones per bit over the whole frame, then apply the rule.
    function automatic void push_model(input logic [WIDTH-1:0] w[$]);
        logic [WIDTH-1:0] d = '0;
        logic [WIDTH-1:0] m = '0;
        for (int b = 0; b < int'(WIDTH); b++) begin
            int ones = 0;
            foreach (w[i]) ones += int'(w[i][b]);
            d[b] = (ones >= int'(THRESH));
            m[b] = (ones != 0) && (ones != int'(NVOTES));
        end
        exp_q.push_back({m, d});
    endfunction

    always @(negedge clk) begin
        if (rst_n && vif.out_valid && vif.out_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [2*WIDTH-1:0] e;
                e = exp_q.pop_front();
                chk("out_data", 32'(vif.out_data), 32'(e[WIDTH-1:0]));
                chk("out_mask", 32'(vif.out_mask), 32'(e[2*WIDTH-1:WIDTH]));
            end
        end
    end

    task automatic send_word(input logic [WIDTH-1:0] w);
        int   n = 0;
        logic acc = 0;
        vif.in_valid = 1;
        vif.in_data  = w;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = vif.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w[$], input bit model, input bit keep);
        if (model) push_model(w);
        foreach (w[i]) send_word(w[i]);
        if (!keep) vif.in_valid = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic void fill(output logic [WIDTH-1:0] w[$], input logic [WIDTH-1:0] a,
                                 input int na, input logic [WIDTH-1:0] b);
        w = {};
        for (int i = 0; i < int'(NVOTES); i++) w.push_back(i < na ? a : b);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] w[$];
        logic [WIDTH-1:0] hd, hm;
        int               n0;

        vif.in_valid = 0;
        vif.in_data  = '0;
        vif.out_ready = 0;
        #23 rst_n = 1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(vif.in_ready), 32'd1);
        chk("rst_out_valid", 32'(vif.out_valid), 32'd0);
        chk("rst_out_data", 32'(vif.out_data), 32'd0);
        chk("rst_out_mask", 32'(vif.out_mask), 32'd0);

        // Unanimous frame: one pulse, visible right after the last accept
        vif.out_ready = 1;
        n0 = hs_cyc.size();
        fill(w, 16'hFFFF, NVOTES, 16'hFFFF);
        send_frame(w, 1, 0);
        chk("lat_valid", 32'(vif.out_valid), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("one_pulse", 32'(hs_cyc.size() - n0), 32'd1);
        chk("valid_low_after", 32'(vif.out_valid), 32'd0);
        wait_drain();

        // Split votes both ways
        fill(w, 16'hAAAA, 5, 16'h5555);
        send_frame(w, 1, 0);
        wait_drain();
        fill(w, 16'hAAAA, 4, 16'h5555);
        send_frame(w, 1, 0);
        wait_drain();

        // Backpressure: held 3 cycles with in_valid still high
        vif.out_ready = 0;
        for (int i = 0; i < int'(NVOTES); i++) w[i] = WIDTH'($urandom);
        send_frame(w, 1, 1);
        hd = vif.out_data;
        hm = vif.out_mask;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(vif.in_ready), 32'd0);
            chk("bp_out_valid", 32'(vif.out_valid), 32'd1);
            chk("bp_data_stable", 32'(vif.out_data), 32'(hd));
            chk("bp_mask_stable", 32'(vif.out_mask), 32'(hm));
            @(posedge clk);
            #1;
        end
        vif.out_ready = 1;
        @(posedge clk);
        #1;
        chk("bp_ready_after", 32'(vif.in_ready), 32'd1);
        chk("bp_valid_after", 32'(vif.out_valid), 32'd0);
        vif.in_valid = 0;
        wait_drain();

        // Mid-frame clear discards the partial frame and the clear-cycle word
        fill(w, 16'hFFFF, NVOTES, 16'hFFFF);
        for (int i = 0; i < 4; i++) send_word(w[i]);
        clear = 1;
        vif.in_valid = 1;
        vif.in_data = 16'hFFFF;
        @(negedge clk);
        chk("clear_in_ready", 32'(vif.in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear = 0;
        fill(w, 16'h0F0F, NVOTES, 16'h0F0F);
        send_frame(w, 1, 0);
        wait_drain();

        // Async reset while holding a result
        vif.out_ready = 0;
        for (int i = 0; i < int'(NVOTES); i++) w[i] = WIDTH'($urandom);
        send_frame(w, 0, 0);
        chk("pre_rst_hold", 32'(vif.out_valid), 32'd1);
        #3 rst_n = 0;
        #1;
        chk("arst_out_valid", 32'(vif.out_valid), 32'd0);
        chk("arst_in_ready", 32'(vif.in_ready), 32'd1);
        chk("arst_out_data", 32'(vif.out_data), 32'd0);
        #2 rst_n = 1;
        @(posedge clk);
        #1;
        vif.out_ready = 1;
        fill(w, 16'h1234, NVOTES, 16'h1234);
        send_frame(w, 1, 0);
        wait_drain();

        // Back-to-back random frames at full rate
        hs_cyc.delete();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < int'(NVOTES); i++) w[i] = WIDTH'($urandom);
            send_frame(w, 1, 1);
        end
        vif.in_valid = 0;
        wait_drain();
        chk("b2b_count", 32'(hs_cyc.size()), 32'd3);
        if (hs_cyc.size() == 3) begin
            chk("b2b_period1", 32'(hs_cyc[1] - hs_cyc[0]), 32'(NVOTES + 1));
            chk("b2b_period2", 32'(hs_cyc[2] - hs_cyc[1]), 32'(NVOTES + 1));
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
